// File: rtl/hash_fold_unit_pkg.sv
// Shared types and default parameters for the key hasher.
package hash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FOLD  = 2'd2,
    DONE  = 2'd3
  } hash_state_e;

  typedef enum logic {
    HASH_MODE_ADD  = 1'b0,
    HASH_MODE_XROT = 1'b1
  } hash_mode_e;

  localparam int HASH_KEY_W = 64;
  localparam int HASH_LANES = 2;
  localparam int HASH_ACC_W = 16;
  localparam int HASH_OUT_W = 8;

endpackage

// File: rtl/hash_fold_unit_if.sv
// Request/response handshake bundle of the key hasher.
// HASH_FOLD_SALT_EN adds the salt_i request field.
interface hash_fold_unit_if #(
  parameter int KEY_W = 64,
  parameter int OUT_W = 8
`ifdef HASH_FOLD_SALT_EN
  ,
  parameter int ACC_W = 16
`endif
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [KEY_W-1:0] key_i;
  logic             mode_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [OUT_W-1:0] hash_val_o;
`ifdef HASH_FOLD_SALT_EN
  logic [ACC_W-1:0] salt_i;

  modport master (
    output req_valid_i, key_i, mode_i, salt_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, hash_val_o
  );
  modport slave (
    input  req_valid_i, key_i, mode_i, salt_i, resp_ready_i,
    output req_ready_o, resp_valid_o, hash_val_o
  );
`else
  modport master (
    output req_valid_i, key_i, mode_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, hash_val_o
  );
  modport slave (
    input  req_valid_i, key_i, mode_i, resp_ready_i,
    output req_ready_o, resp_valid_o, hash_val_o
  );
`endif
endinterface

// File: rtl/hash_lane_mix.sv
// Combinational absorb of LANES key bytes into the accumulator, byte 0 first.
module hash_lane_mix
  import hash_pkg::*;
#(
  parameter int ACC_W = HASH_ACC_W,
  parameter int LANES = HASH_LANES
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [8*LANES-1:0] chunk,
  input  hash_mode_e         mode,
  output logic [ACC_W-1:0]   acc_next
);

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < LANES; i++) begin
      if (mode == HASH_MODE_ADD)
        acc_next = acc_next + ACC_W'(chunk[8*i +: 8]);
      else
        acc_next = {acc_next[ACC_W-2:0], acc_next[ACC_W-1]} ^ ACC_W'(chunk[8*i +: 8]);
    end
  end

endmodule

// File: rtl/hash_fold_unit.sv
// Multi-cycle key hasher: absorbs the key LANES bytes per cycle, folds to OUT_W.
// HASH_FOLD_SALT_EN seeds the accumulator from salt_i instead of zero.
module hash_fold_unit
  import hash_pkg::*;
#(
  parameter int KEY_W = HASH_KEY_W,
  parameter int LANES = HASH_LANES,
  parameter int ACC_W = HASH_ACC_W,
  parameter int OUT_W = HASH_OUT_W
) (
  input logic             clk,
  input logic             rst,
  hash_fold_unit_if.slave bus
);

  localparam int NBYTES  = KEY_W / 8;
  localparam int CHUNK_W = 8 * LANES;
  localparam int NSLICE  = ACC_W / OUT_W;
  localparam int IDX_W   = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - LANES);

  generate
    if ((KEY_W % (8 * LANES)) != 0) begin : g_bad_key_w
      $error("hash_fold_unit: KEY_W must be a multiple of 8*LANES");
    end
    if ((ACC_W % OUT_W) != 0) begin : g_bad_acc_w
      $error("hash_fold_unit: ACC_W must be a multiple of OUT_W");
    end
  endgenerate

  function automatic logic [OUT_W-1:0] fold(input logic [ACC_W-1:0] acc,
                                            input hash_mode_e mode);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (mode == HASH_MODE_ADD) r = r + acc[s*OUT_W +: OUT_W];
      else                       r = r ^ acc[s*OUT_W +: OUT_W];
    end
    return r;
  endfunction

  hash_state_e      state_q, state_d;
  hash_mode_e       mode_q;
  logic [KEY_W-1:0] key_q;
  logic [ACC_W-1:0] acc_q, acc_mix, acc_init;
  logic [IDX_W-1:0] idx_q;
  logic [OUT_W-1:0] hash_q;
  logic             req_ready, resp_valid;

`ifdef HASH_FOLD_SALT_EN
  assign acc_init = bus.salt_i;
`else
  assign acc_init = '0;
`endif

  hash_lane_mix #(.ACC_W(ACC_W), .LANES(LANES)) u_mix (
    .acc      (acc_q),
    .chunk    (key_q[CHUNK_W-1:0]),
    .mode     (mode_q),
    .acc_next (acc_mix)
  );

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid_i) state_d = ACCUM;
      end
      ACCUM: if (idx_q == IDX_LAST) state_d = FOLD;
      FOLD:  state_d = DONE;
      DONE: begin
        resp_valid = 1'b1;
        if (bus.resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The key register shifts down one chunk per absorb, so the mixer always sees bits [CHUNK_W-1:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.req_valid_i) begin
          key_q  <= bus.key_i;
          mode_q <= hash_mode_e'(bus.mode_i);
          acc_q  <= acc_init;
          idx_q  <= '0;
        end
        ACCUM: begin
          acc_q <= acc_mix;
          idx_q <= idx_q + IDX_STEP;
          key_q <= key_q >> CHUNK_W;
        end
        FOLD:    hash_q <= fold(acc_q, mode_q);
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.hash_val_o   = hash_q;

endmodule

// File: tb/tb_hash_fold_unit.sv
// Directed bench for hash_fold_unit: vector table plus backpressure and reset sequences.
module tb_hash_fold_unit;
  localparam int KEY_W = 64;
  localparam int LANES = 2;
  localparam int ACC_W = 16;
  localparam int OUT_W = 8;
  localparam int LAT   = KEY_W / (8 * LANES) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hash_fold_unit_if #(.KEY_W(KEY_W), .OUT_W(OUT_W)
`ifdef HASH_FOLD_SALT_EN
    , .ACC_W(ACC_W)
`endif
  ) bus ();

  hash_fold_unit #(.KEY_W(KEY_W), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [63:0] key;
    logic        mode;
    logic [7:0]  exp_hash;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold the request until accepted; scramble the key inputs afterwards.
  task automatic send(input logic [63:0] key, input logic mode);
    int n = 0;
    bus.req_valid_i = 1'b1;
    bus.key_i       = key;
    bus.mode_i      = mode;
    while (!bus.req_ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: req_ready_o never rose");
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.key_i       = ~key;
    bus.mode_i      = ~mode;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.resp_valid_o && lat < 50);
    if (!bus.resp_valid_o) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid_o never rose");
    end
  endtask

  task automatic ack();
    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
    check("ready_after_ack", 64'(bus.req_ready_o), 64'd1);
    check("valid_after_ack", 64'(bus.resp_valid_o), 64'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] held;

    vecs[0] = '{"add_seq",   64'h0102030405060708, 1'b0, 8'h24};
    vecs[1] = '{"add_ones",  64'hFFFFFFFFFFFFFFFF, 1'b0, 8'hFF};
    vecs[2] = '{"xrot_b0",   64'h0000000000000001, 1'b1, 8'h80};
    vecs[3] = '{"xrot_b7",   64'h0100000000000000, 1'b1, 8'h01};
    vecs[4] = '{"xrot_seq",  64'h0102030405060708, 1'b1, 8'h7C};
    vecs[5] = '{"xrot_ones", 64'hFFFFFFFFFFFFFFFF, 1'b1, 8'h00};
    vecs[6] = '{"add_80s",   64'h8080808080808080, 1'b0, 8'h04};
    vecs[7] = '{"add_low",   64'h00000000000000FF, 1'b0, 8'hFF};
    vecs[8] = '{"xrot_low",  64'h00000000000000FF, 1'b1, 8'hFF};
    vecs[9] = '{"add_zero",  64'h0000000000000000, 1'b0, 8'h00};

    bus.req_valid_i  = 1'b0;
    bus.key_i        = '0;
    bus.mode_i       = 1'b0;
    bus.resp_ready_i = 1'b0;
`ifdef HASH_FOLD_SALT_EN
    bus.salt_i       = '0;
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_ready",  64'(bus.req_ready_o), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    check("rst_hash_val",   64'(bus.hash_val_o), 64'd0);

    // resp_ready while idle must not disturb anything
    bus.resp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.resp_ready_i = 1'b0;
    check("idle_ack_ready", 64'(bus.req_ready_o), 64'd1);
    check("idle_ack_valid", 64'(bus.resp_valid_o), 64'd0);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].key, vecs[i].mode);
      wait_resp(lat);
      check({vecs[i].name, "_lat"},  64'(lat), 64'(LAT));
      check({vecs[i].name, "_hash"}, 64'(bus.hash_val_o), 64'(vecs[i].exp_hash));
      ack();
      check({vecs[i].name, "_hold"}, 64'(bus.hash_val_o), 64'(vecs[i].exp_hash));
    end

    // Backpressure: response held while a competing request waits
    send(64'h0102030405060708, 1'b0);
    wait_resp(lat);
    held = bus.hash_val_o;
    check("bp_first_hash", 64'(held), 64'h24);
    bus.req_valid_i = 1'b1;
    bus.key_i       = 64'hFFFFFFFFFFFFFFFF;
    bus.mode_i      = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hash_stable", 64'(bus.hash_val_o), 64'(held));
      check("bp_valid_held",  64'(bus.resp_valid_o), 64'd1);
      check("bp_ready_low",   64'(bus.req_ready_o), 64'd0);
    end
    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
    check("bp_release_ready", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check("bp_accepted", 64'(bus.req_ready_o), 64'd0);
    wait_resp(lat);
    check("bp_second_lat",  64'(lat), 64'(LAT));
    check("bp_second_hash", 64'(bus.hash_val_o), 64'hFF);
    ack();

    // Reset in the second accumulate cycle aborts silently
    send(64'h8080808080808080, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", 64'(bus.req_ready_o), 64'd1);
    check("mid_rst_valid", 64'(bus.resp_valid_o), 64'd0);
    check("mid_rst_hash",  64'(bus.hash_val_o), 64'd0);
    begin
      int seen = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (bus.resp_valid_o) seen++;
      end
      check("mid_rst_no_resp", 64'(seen), 64'd0);
    end
    send(64'h0102030405060708, 1'b0);
    wait_resp(lat);
    check("post_rst_lat",  64'(lat), 64'(LAT));
    check("post_rst_hash", 64'(bus.hash_val_o), 64'h24);
    ack();

`ifdef HASH_FOLD_SALT_EN
    bus.salt_i = 16'h0100;
    send(64'h0102030405060708, 1'b0);
    bus.salt_i = 16'h5555;
    wait_resp(lat);
    check("salt_lat",  64'(lat), 64'(LAT));
    check("salt_hash", 64'(bus.hash_val_o), 64'h25);
    ack();
    bus.salt_i = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
